input_conditioner: RTL and testbench

- Parametrised multi-channel input front end for the traffic light controller.
- Replaces single-flop sampling with per-channel N-stage synchronisers, a consecutive-cycle debounce filter and one-cycle rise/fall pulses.
- Sits between the board pins (reset-exempt raw sensor, walk and reprogram inputs) and the controller FSM/timer.
- Channels are fully independent. Only the shared counter-width logic is common.

---
 rtl/input_conditioner.sv | 121 ++++++++++++
 tb/tb_input_conditioner.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/input_conditioner.sv
// input_conditioner: per-channel input front end for the traffic light controller.
// Each channel: optional inversion -> SYNC_STAGES-flop synchroniser -> debounce filter
// -> registered one-cycle rise/fall pulses. Channels are fully independent.
// Latency: a clean raw edge reaches Stable_Out SYNC_STAGES+DEBOUNCE_CYCLES-1 posedges
// after the first posedge that samples it. Input is never back-pressured.
// Ports:
//   clk          system clock, all state on posedge
//   Reset_n      asynchronous active-low reset
//   Raw_In       asynchronous raw pin levels (one bit per channel)
//   Stable_Out   debounced, synchronised level
//   Rise_Pulse   one-cycle pulse in the cycle Stable_Out goes 0->1
//   Fall_Pulse   one-cycle pulse in the cycle Stable_Out goes 1->0
//   Latch_Clr    (INPUT_COND_LATCH_EN only) clears Latched_Req per channel
//   Latched_Req  (INPUT_COND_LATCH_EN only) sticky request, set by Rise_Pulse
// Optional feature macro: INPUT_COND_LATCH_EN adds the request latch ports/flops.
// Note for the controller: a channel with INVERT_MASK set whose pin is held low
// through reset leaves reset at 0 and then produces a Rise_Pulse
// SYNC_STAGES+DEBOUNCE_CYCLES cycles after release. This is intended behaviour.

module input_conditioner #(
  parameter int                NUM_CH          = 4,
  parameter int                SYNC_STAGES     = 2,
  parameter int                DEBOUNCE_CYCLES = 16,
  parameter logic [NUM_CH-1:0] INVERT_MASK     = {NUM_CH{1'b0}},
  localparam int               CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic              clk,
  input  logic              Reset_n,
  input  logic [NUM_CH-1:0] Raw_In,
`ifdef INPUT_COND_LATCH_EN
  input  logic [NUM_CH-1:0] Latch_Clr,
  output logic [NUM_CH-1:0] Latched_Req,
`endif
  output logic [NUM_CH-1:0] Stable_Out,
  output logic [NUM_CH-1:0] Rise_Pulse,
  output logic [NUM_CH-1:0] Fall_Pulse
);

  // Parameter legality, caught at elaboration.
  if (NUM_CH < 1 || NUM_CH > 32) begin : g_bad_num_ch
    $error("input_conditioner: NUM_CH must be in 1..32");
  end
  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
    $error("input_conditioner: SYNC_STAGES must be in 2..4");
  end
  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 65535) begin : g_bad_debounce
    $error("input_conditioner: DEBOUNCE_CYCLES must be in 1..65535");
  end

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Synchroniser chain, stage 0 samples the (possibly inverted) pins.
  logic [NUM_CH-1:0] sync_q [SYNC_STAGES];

  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= '0;
      end
    end else begin
      sync_q[0] <= Raw_In ^ INVERT_MASK;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic             sync_lvl;
    logic             stable_q;
    logic             rise_q;
    logic             fall_q;
    logic             update;
    logic [CNT_W-1:0] cnt_q;

    assign sync_lvl = sync_q[SYNC_STAGES-1][i];
    // The level flips once the mismatch has been seen DEBOUNCE_CYCLES times in a row;
    // cnt_q holds how many consecutive mismatches came before this cycle.
    assign update   = (sync_lvl != stable_q) && (cnt_q == CNT_LAST);

    always_ff @(posedge clk or negedge Reset_n) begin
      if (!Reset_n) begin
        cnt_q    <= '0;
        stable_q <= 1'b0;
        rise_q   <= 1'b0;
        fall_q   <= 1'b0;
      end else begin
        if (sync_lvl == stable_q) begin
          cnt_q <= '0;
        end else if (update) begin
          cnt_q    <= '0;
          stable_q <= sync_lvl;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
        rise_q <= update & sync_lvl;
        fall_q <= update & ~sync_lvl;
      end
    end

    assign Stable_Out[i] = stable_q;
    assign Rise_Pulse[i] = rise_q;
    assign Fall_Pulse[i] = fall_q;

`ifdef INPUT_COND_LATCH_EN
    // Holds a request until serviced; a set arriving with a clear wins.
    logic latch_q;

    always_ff @(posedge clk or negedge Reset_n) begin
      if (!Reset_n) begin
        latch_q <= 1'b0;
      end else begin
        latch_q <= rise_q | (latch_q & ~Latch_Clr[i]);
      end
    end

    assign Latched_Req[i] = latch_q;
`endif
  end

endmodule

// File: tb/tb_input_conditioner.sv
// Bench for input_conditioner: two instances (no inversion / channel 3 inverted)
// share the stimulus; a window-based model predicts every output each cycle and
// directed checks pin the key timings with literal values.

module tb_input_conditioner;

  localparam int         SYNC  = 2;
  localparam int         DEB   = 4;
  localparam int         HL    = SYNC + DEB;
  localparam logic [3:0] MASK0 = 4'b0000;
  localparam logic [3:0] MASK1 = 4'b1000;

  logic       clk = 1'b0;
  logic       Reset_n;
  logic [3:0] Raw_In;
  logic [3:0] so0, rp0, fp0;
  logic [3:0] so1, rp1, fp1;
`ifdef INPUT_COND_LATCH_EN
  logic [3:0] Latch_Clr;
  logic [3:0] lr0, lr1;
`endif

  int pass_cnt = 0;
  int total    = 0;

  always #5 clk = ~clk;

  input_conditioner #(
    .NUM_CH(4), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB), .INVERT_MASK(MASK0)
  ) dut (
    .clk(clk),
    .Reset_n(Reset_n),
    .Raw_In(Raw_In),
`ifdef INPUT_COND_LATCH_EN
    .Latch_Clr(Latch_Clr),
    .Latched_Req(lr0),
`endif
    .Stable_Out(so0),
    .Rise_Pulse(rp0),
    .Fall_Pulse(fp0)
  );

  input_conditioner #(
    .NUM_CH(4), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB), .INVERT_MASK(MASK1)
  ) dut_inv (
    .clk(clk),
    .Reset_n(Reset_n),
    .Raw_In(Raw_In),
`ifdef INPUT_COND_LATCH_EN
    .Latch_Clr(Latch_Clr),
    .Latched_Req(lr1),
`endif
    .Stable_Out(so1),
    .Rise_Pulse(rp1),
    .Fall_Pulse(fp1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Model: xh[d][k] is the conditioned pin value sampled k posedges ago (0 = this edge).
  // The synchronised level seen at this edge is xh[SYNC]; the debounced level flips
  // when the last DEB synchronised samples all disagree with it.
  logic [3:0] xh [2][HL];
  logic [3:0] ms [2];
  logic [3:0] mr [2];
  logic [3:0] mf [2];
`ifdef INPUT_COND_LATCH_EN
  logic [3:0] ml [2];
`endif

  initial begin
    forever begin
      @(posedge clk or negedge Reset_n);
      for (int d = 0; d < 2; d++) begin
        if (!Reset_n) begin
          for (int k = 0; k < HL; k++) xh[d][k] = '0;
          ms[d] = '0;
          mr[d] = '0;
          mf[d] = '0;
`ifdef INPUT_COND_LATCH_EN
          ml[d] = '0;
`endif
        end else begin
`ifdef INPUT_COND_LATCH_EN
          ml[d] = mr[d] | (ml[d] & ~Latch_Clr);
`endif
          for (int k = HL - 1; k > 0; k--) xh[d][k] = xh[d][k-1];
          xh[d][0] = Raw_In ^ ((d == 0) ? MASK0 : MASK1);
          for (int c = 0; c < 4; c++) begin
            bit all_diff;
            all_diff = 1'b1;
            for (int j = 0; j < DEB; j++) begin
              if (xh[d][SYNC+j][c] == ms[d][c]) all_diff = 1'b0;
            end
            mr[d][c] = all_diff & ~ms[d][c];
            mf[d][c] = all_diff & ms[d][c];
            if (all_diff) ms[d][c] = ~ms[d][c];
          end
        end
      end
      #1;
      check("model_stable0", so0, ms[0]);
      check("model_rise0",   rp0, mr[0]);
      check("model_fall0",   fp0, mf[0]);
      check("model_stable1", so1, ms[1]);
      check("model_rise1",   rp1, mr[1]);
      check("model_fall1",   fp1, mf[1]);
`ifdef INPUT_COND_LATCH_EN
      check("model_latch0",  lr0, ml[0]);
      check("model_latch1",  lr1, ml[1]);
`endif
    end
  end

  initial begin
    bit seen;
    Reset_n = 1'b0;
    Raw_In  = '0;
`ifdef INPUT_COND_LATCH_EN
    Latch_Clr = '0;
`endif
    @(negedge clk);
    check("reset_stable", {so1, so0}, 8'h00);
    check("reset_rise",   {rp1, rp0}, 8'h00);
    check("reset_fall",   {fp1, fp0}, 8'h00);
    @(negedge clk);
    Reset_n = 1'b1;                       // next posedge is edge 1

    // Clean rise on ch0 raised after edge 10: level and pulse at edge 16.
    repeat (10) @(negedge clk);
    Raw_In[0] = 1'b1;
    repeat (5) @(negedge clk);
    check("t1_before", so0[0], 1'b0);
    @(negedge clk);
    check("t1_stable", so0, 4'b0001);
    check("t1_rise",   rp0, 4'b0001);
    @(negedge clk);
    check("t1_rise_once", rp0, 4'b0000);
    check("t1_hold",      so0, 4'b0001);

    // Ch1: 3-cycle glitch is filtered; 4-cycle pulse passes.
    Raw_In[1] = 1'b1;
    repeat (3) @(negedge clk);
    Raw_In[1] = 1'b0;
    repeat (10) @(negedge clk);
    check("t2_short_filtered", so0[1], 1'b0);
    Raw_In[1] = 1'b1;
    repeat (4) @(negedge clk);
    Raw_In[1] = 1'b0;
    @(negedge clk);
    check("t2_pre_rise", rp0[1], 1'b0);
    @(negedge clk);
    check("t2_rise", rp0[1], 1'b1);
    repeat (3) @(negedge clk);
    check("t2_pre_fall", fp0[1], 1'b0);
    @(negedge clk);
    check("t2_fall", fp0[1], 1'b1);
    check("t2_stable_low", so0[1], 1'b0);

    // Ch2 toggling every cycle must never get through.
    repeat (5) @(negedge clk);
    seen = 1'b0;
    for (int k = 0; k < 50; k++) begin
      Raw_In[2] = ~Raw_In[2];
      @(negedge clk);
      if (so0[2] | rp0[2] | fp0[2]) seen = 1'b1;
    end
    check("t3_toggle_blocked", seen, 1'b0);
    repeat (8) @(negedge clk);
    check("t3_stable", so0[2], 1'b0);

    // Ch3 high, then drop it and reset asynchronously with the count at 2.
    Raw_In = 4'b1000;
    repeat (8) @(negedge clk);
    check("t4_ch3_high", so0, 4'b1000);
    Raw_In[3] = 1'b0;
    repeat (4) @(negedge clk);
    #2;
    Reset_n = 1'b0;
    #1;
    check("t4_async_stable", {so1, so0}, 8'h00);
    check("t4_async_pulses", {rp1, rp0, fp1, fp0}, 16'h0000);
    @(negedge clk);
    @(negedge clk);
    Reset_n = 1'b1;

    // Inverted ch3 held low through release rises 6 edges later; dut stays quiet.
    repeat (5) @(negedge clk);
    check("t5_inv_pre_rise", rp1[3], 1'b0);
    @(negedge clk);
    check("t5_inv_rise",   rp1[3], 1'b1);
    check("t5_inv_stable", so1[3], 1'b1);
    check("t4_no_pulse",   {so0, rp0, fp0}, 12'h000);
    Raw_In[3] = 1'b1;
    repeat (5) @(negedge clk);
    check("t5_inv_pre_fall", fp1[3], 1'b0);
    @(negedge clk);
    check("t5_inv_fall", fp1[3], 1'b1);
    check("t5_inv_low",  so1[3], 1'b0);

`ifdef INPUT_COND_LATCH_EN
    // Request latch: set by rise, cleared by a later clear, set wins on collision.
    Raw_In = '0;
    repeat (8) @(negedge clk);
    Raw_In[0] = 1'b1;
    repeat (6) @(negedge clk);
    check("t6_rise",        rp0[0], 1'b1);
    check("t6_latch_early", lr0[0], 1'b0);
    @(negedge clk);
    check("t6_latch_set", lr0[0], 1'b1);
    repeat (4) @(negedge clk);
    check("t6_latch_held", lr0[0], 1'b1);
    Latch_Clr[0] = 1'b1;
    @(negedge clk);
    Latch_Clr[0] = 1'b0;
    check("t6_latch_cleared", lr0[0], 1'b0);
    Raw_In[0] = 1'b0;
    repeat (8) @(negedge clk);
    Raw_In[0] = 1'b1;
    repeat (6) @(negedge clk);
    check("t6_rise2", rp0[0], 1'b1);
    Latch_Clr[0] = 1'b1;
    @(negedge clk);
    Latch_Clr[0] = 1'b0;
    check("t6_set_wins", lr0[0], 1'b1);
`endif

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
